// File: rtl/core_pipe_wb.sv
// Writeback stage (s3): completes memory responses with load extraction, performs CSR
// accesses, writes the register file, raises traps and pulses instruction retirement.
module core_pipe_wb #(
  parameter int XLEN         = 64,
  parameter int TRAP_CAUSE_W = 7
) (
  input  logic                    g_clk,
  input  logic                    g_reset,
  input  logic                    s3_full,
  output logic                    s3_ready,
  input  logic [XLEN-1:0]         s3_pc,
  input  logic [31:0]             s3_instr,
  input  logic [XLEN-1:0]         s3_wdata,
  input  logic [4:0]              s3_rd,
  input  logic [6:0]              s3_lsu_op,
  input  logic [3:0]              s3_csr_op,
  input  logic [11:0]             s3_csr_addr,
  input  logic [1:0]              s3_wb_op,
  input  logic                    s3_trap,
  input  logic                    dmem_rsp_valid,
  input  logic                    dmem_rsp_err,
  input  logic [XLEN-1:0]         dmem_rsp_rdata,
  output logic                    csr_en,
  output logic                    csr_wr,
  output logic                    csr_set,
  output logic                    csr_clr,
  output logic [11:0]             csr_addr,
  output logic [XLEN-1:0]         csr_wdata,
  input  logic [XLEN-1:0]         csr_rdata,
  input  logic                    csr_error,
  output logic                    rd_wen,
  output logic [4:0]              rd_addr,
  output logic [XLEN-1:0]         rd_wdata,
  output logic                    trap_valid,
  output logic [TRAP_CAUSE_W-1:0] trap_cause,
  output logic [XLEN-1:0]         trap_pc,
  input  logic                    trap_ack,
  output logic                    wb_flush,
  output logic                    instr_ret
);

  typedef enum logic [1:0] {ST_RUN, ST_WAIT_MEM, ST_TRAP} state_e;

  localparam logic [TRAP_CAUSE_W-1:0] CAUSE_ILLEGAL  = TRAP_CAUSE_W'(2);
  localparam logic [TRAP_CAUSE_W-1:0] CAUSE_LD_FAULT = TRAP_CAUSE_W'(5);
  localparam logic [TRAP_CAUSE_W-1:0] CAUSE_ST_FAULT = TRAP_CAUSE_W'(7);

  localparam logic [1:0] WB_WDATA = 2'd1;
  localparam logic [1:0] WB_LSU   = 2'd2;
  localparam logic [1:0] WB_CSR   = 2'd3;

  state_e                  state_q, state_d;
  logic                    rd_wen_q, rd_wen_d;
  logic [4:0]              rd_addr_q, rd_addr_d;
  logic [XLEN-1:0]         rd_wdata_q, rd_wdata_d;
  logic                    trap_valid_q, trap_valid_d;
  logic [TRAP_CAUSE_W-1:0] trap_cause_q, trap_cause_d;
  logic [XLEN-1:0]         trap_pc_q, trap_pc_d;
  logic                    instr_ret_q, instr_ret_d;

  logic                    is_lsu, is_csr, store_only;
  logic                    complete, raise_trap;
  logic [TRAP_CAUSE_W-1:0] raise_cause;
  logic [TRAP_CAUSE_W-1:0] mem_cause;
  logic [XLEN-1:0]         ld_shifted, ld_value;
  logic                    ld_sign;

  assign is_lsu     = s3_lsu_op[0] | s3_lsu_op[1];
  assign store_only = s3_lsu_op[1] & ~s3_lsu_op[0];
  assign is_csr     = |s3_csr_op;
  assign mem_cause  = s3_lsu_op[0] ? CAUSE_LD_FAULT : CAUSE_ST_FAULT;

  // Response data is a whole aligned doubleword; the address low bits pick the lanes.
  always_comb begin
    ld_shifted = dmem_rsp_rdata >> {s3_wdata[2:0], 3'b000};
    ld_sign    = 1'b0;
    ld_value   = ld_shifted;
    if (s3_lsu_op[2]) begin
      ld_sign  = s3_lsu_op[6] & ld_shifted[7];
      ld_value = {{(XLEN-8){ld_sign}}, ld_shifted[7:0]};
    end else if (s3_lsu_op[3]) begin
      ld_sign  = s3_lsu_op[6] & ld_shifted[15];
      ld_value = {{(XLEN-16){ld_sign}}, ld_shifted[15:0]};
    end else if (s3_lsu_op[4]) begin
      ld_sign  = s3_lsu_op[6] & ld_shifted[31];
      ld_value = {{(XLEN-32){ld_sign}}, ld_shifted[31:0]};
    end
  end

  // NOTE: every signal written here gets a default first so no path infers a latch.
  always_comb begin
    state_d     = state_q;
    s3_ready    = 1'b0;
    csr_en      = 1'b0;
    complete    = 1'b0;
    raise_trap  = 1'b0;
    raise_cause = CAUSE_ILLEGAL;
    trap_valid_d = trap_valid_q;

    case (state_q)
      ST_RUN: begin
        if (!s3_full) begin
          s3_ready = 1'b1;
        end else if (s3_trap) begin
          raise_trap = 1'b1;
        end else if (is_lsu) begin
          if (!dmem_rsp_valid) begin
            state_d = ST_WAIT_MEM;
          end else if (dmem_rsp_err) begin
            raise_trap  = 1'b1;
            raise_cause = mem_cause;
          end else begin
            complete = 1'b1;
          end
        end else if (is_csr) begin
          csr_en = 1'b1;
          if (csr_error) raise_trap = 1'b1;
          else           complete   = 1'b1;
        end else begin
          complete = 1'b1;
        end
      end
      ST_WAIT_MEM: begin
        if (dmem_rsp_valid) begin
          if (dmem_rsp_err) begin
            raise_trap  = 1'b1;
            raise_cause = mem_cause;
          end else begin
            complete = 1'b1;
            state_d  = ST_RUN;
          end
        end
      end
      ST_TRAP: begin
        if (trap_ack) begin
          s3_ready     = 1'b1;
          trap_valid_d = 1'b0;
          state_d      = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase

    if (complete) s3_ready = 1'b1;
    if (raise_trap) begin
      state_d      = ST_TRAP;
      trap_valid_d = 1'b1;
    end
  end

  always_comb begin
    trap_cause_d = raise_trap ? raise_cause : trap_cause_q;
    trap_pc_d    = raise_trap ? s3_pc       : trap_pc_q;
    instr_ret_d  = complete;
    rd_wen_d     = complete && (s3_wb_op != 2'd0) && (s3_rd != 5'd0) && !store_only;
    rd_addr_d    = complete ? s3_rd : rd_addr_q;
    rd_wdata_d   = rd_wdata_q;
    if (complete) begin
      case (s3_wb_op)
        WB_LSU:   rd_wdata_d = ld_value;
        WB_CSR:   rd_wdata_d = csr_rdata;
        WB_WDATA: rd_wdata_d = s3_wdata;
        default:  rd_wdata_d = s3_wdata;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops sample together.
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      state_q      <= ST_RUN;
      rd_wen_q     <= 1'b0;
      rd_addr_q    <= '0;
      rd_wdata_q   <= '0;
      trap_valid_q <= 1'b0;
      trap_cause_q <= '0;
      trap_pc_q    <= '0;
      instr_ret_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_wen_q     <= rd_wen_d;
      rd_addr_q    <= rd_addr_d;
      rd_wdata_q   <= rd_wdata_d;
      trap_valid_q <= trap_valid_d;
      trap_cause_q <= trap_cause_d;
      trap_pc_q    <= trap_pc_d;
      instr_ret_q  <= instr_ret_d;
    end
  end

  assign csr_wr     = csr_en & s3_csr_op[1];
  assign csr_set    = csr_en & s3_csr_op[2];
  assign csr_clr    = csr_en & s3_csr_op[3];
  assign csr_addr   = s3_csr_addr;
  assign csr_wdata  = s3_wdata;

  assign rd_wen     = rd_wen_q;
  assign rd_addr    = rd_addr_q;
  assign rd_wdata   = rd_wdata_q;
  assign trap_valid = trap_valid_q;
  assign trap_cause = trap_cause_q;
  assign trap_pc    = trap_pc_q;
  assign wb_flush   = trap_valid_q & trap_ack;
  assign instr_ret  = instr_ret_q;

  logic unused_ok;
  assign unused_ok = ^s3_instr;

endmodule

// File: tb/tb_core_pipe_wb.sv
// Directed and randomized bench for core_pipe_wb; expectations come from an
// instruction-level model of writeback, load extraction and trap rules.
module tb_core_pipe_wb;

  localparam int XLEN = 64;

  logic        g_clk = 1'b0;
  logic        g_reset;
  logic        s3_full, s3_ready;
  logic [63:0] s3_pc, s3_wdata;
  logic [31:0] s3_instr;
  logic [4:0]  s3_rd;
  logic [6:0]  s3_lsu_op;
  logic [3:0]  s3_csr_op;
  logic [11:0] s3_csr_addr;
  logic [1:0]  s3_wb_op;
  logic        s3_trap;
  logic        dmem_rsp_valid, dmem_rsp_err;
  logic [63:0] dmem_rsp_rdata;
  logic        csr_en, csr_wr, csr_set, csr_clr;
  logic [11:0] csr_addr;
  logic [63:0] csr_wdata, csr_rdata;
  logic        csr_error;
  logic        rd_wen;
  logic [4:0]  rd_addr;
  logic [63:0] rd_wdata;
  logic        trap_valid;
  logic [6:0]  trap_cause;
  logic [63:0] trap_pc;
  logic        trap_ack, wb_flush, instr_ret;

  int n_checks = 0;
  int n_errors = 0;

  always #5 g_clk = ~g_clk;

  core_pipe_wb #(.XLEN(XLEN), .TRAP_CAUSE_W(7)) dut (
    .g_clk(g_clk), .g_reset(g_reset),
    .s3_full(s3_full), .s3_ready(s3_ready), .s3_pc(s3_pc), .s3_instr(s3_instr),
    .s3_wdata(s3_wdata), .s3_rd(s3_rd), .s3_lsu_op(s3_lsu_op), .s3_csr_op(s3_csr_op),
    .s3_csr_addr(s3_csr_addr), .s3_wb_op(s3_wb_op), .s3_trap(s3_trap),
    .dmem_rsp_valid(dmem_rsp_valid), .dmem_rsp_err(dmem_rsp_err), .dmem_rsp_rdata(dmem_rsp_rdata),
    .csr_en(csr_en), .csr_wr(csr_wr), .csr_set(csr_set), .csr_clr(csr_clr),
    .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .csr_error(csr_error),
    .rd_wen(rd_wen), .rd_addr(rd_addr), .rd_wdata(rd_wdata),
    .trap_valid(trap_valid), .trap_cause(trap_cause), .trap_pc(trap_pc),
    .trap_ack(trap_ack), .wb_flush(wb_flush), .instr_ret(instr_ret)
  );

  typedef struct packed {
    logic [1:0]  wb_op;
    logic [6:0]  lsu_op;
    logic [3:0]  csr_op;
    logic [4:0]  rd;
    logic [63:0] wdata;
    logic [63:0] pc;
    logic [11:0] csr_addr;
    logic [3:0]  lat;
    logic [63:0] rdata;
    logic        err;
    logic [63:0] csr_rdata;
    logic        csr_err;
    logic        trap;
    logic [3:0]  ack_dly;
  } instr_t;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge g_clk);
    #1;
  endtask

  // Loaded value: select 1/2/4/8 bytes starting at the byte offset, then zero/sign fill.
  function automatic logic [63:0] load_model(input logic [63:0] rdata, input logic [2:0] off,
                                             input logic [6:0] op);
    int          nbytes;
    logic [63:0] v, mask;
    nbytes = op[2] ? 1 : op[3] ? 2 : op[4] ? 4 : 8;
    v = rdata >> (8 * int'(off));
    if (nbytes < 8) begin
      mask = (64'd1 << (8 * nbytes)) - 64'd1;
      v = v & mask;
      if (op[6] && v[8*nbytes-1]) v = v | ~mask;
    end
    return v;
  endfunction

  task automatic run(input instr_t t);
    logic        is_lsu, exp_trap, exp_wen;
    logic [6:0]  exp_cause;
    logic [63:0] exp_data;
    is_lsu    = t.lsu_op[0] | t.lsu_op[1];
    exp_trap  = 1'b0;
    exp_cause = 7'd2;
    s3_full = 1'b1; s3_pc = t.pc; s3_wdata = t.wdata; s3_rd = t.rd;
    s3_lsu_op = t.lsu_op; s3_csr_op = t.csr_op; s3_csr_addr = t.csr_addr;
    s3_wb_op = t.wb_op; s3_trap = t.trap; s3_instr = $urandom;
    csr_rdata = t.csr_rdata; csr_error = t.csr_err; trap_ack = 1'b0;
    dmem_rsp_valid = 1'b0; dmem_rsp_err = 1'b0; dmem_rsp_rdata = $urandom;

    if (t.trap) begin
      #3;
      check("trap_in_ready", s3_ready, 0);
      check("trap_in_csr_en", csr_en, 0);
      tick();
      exp_trap = 1'b1;
    end else if (is_lsu) begin
      for (int c = 0; c < int'(t.lat); c++) begin
        #3;
        check("mem_wait_ready", s3_ready, 0);
        check("mem_wait_csr_en", csr_en, 0);
        tick();
      end
      dmem_rsp_valid = 1'b1; dmem_rsp_rdata = t.rdata; dmem_rsp_err = t.err;
      #3;
      check("mem_rsp_ready", s3_ready, !t.err);
      tick();
      exp_trap  = t.err;
      exp_cause = t.lsu_op[0] ? 7'd5 : 7'd7;
    end else if (t.csr_op != 4'd0) begin
      #3;
      check("csr_en", csr_en, 1);
      check("csr_wr", csr_wr, t.csr_op[1]);
      check("csr_set", csr_set, t.csr_op[2]);
      check("csr_clr", csr_clr, t.csr_op[3]);
      check("csr_addr", csr_addr, t.csr_addr);
      check("csr_wdata", csr_wdata, t.wdata);
      check("csr_ready", s3_ready, !t.csr_err);
      tick();
      exp_trap = t.csr_err;
    end else begin
      #3;
      check("alu_ready", s3_ready, 1);
      tick();
    end
    dmem_rsp_valid = 1'b0; dmem_rsp_err = 1'b0;

    if (exp_trap) begin
      check("trap_valid", trap_valid, 1);
      check("trap_cause", trap_cause, exp_cause);
      check("trap_pc", trap_pc, t.pc);
      check("trap_rd_wen", rd_wen, 0);
      check("trap_instr_ret", instr_ret, 0);
      for (int c = 0; c < int'(t.ack_dly); c++) begin
        #3;
        check("trap_hold_ready", s3_ready, 0);
        check("trap_hold_csr_en", csr_en, 0);
        check("trap_hold_flush", wb_flush, 0);
        tick();
        check("trap_hold_valid", trap_valid, 1);
      end
      trap_ack = 1'b1;
      #3;
      check("ack_flush", wb_flush, 1);
      check("ack_ready", s3_ready, 1);
      tick();
      s3_full = 1'b0; trap_ack = 1'b0;
      check("post_ack_valid", trap_valid, 0);
      check("post_ack_flush", wb_flush, 0);
      check("post_ack_rd_wen", rd_wen, 0);
      check("post_ack_instr_ret", instr_ret, 0);
    end else begin
      s3_full  = 1'b0;
      exp_wen  = (t.wb_op != 2'd0) && (t.rd != 5'd0) && !(t.lsu_op[1] && !t.lsu_op[0]);
      exp_data = (t.wb_op == 2'd2) ? load_model(t.rdata, t.wdata[2:0], t.lsu_op) :
                 (t.wb_op == 2'd3) ? t.csr_rdata : t.wdata;
      check("ret_instr_ret", instr_ret, 1);
      check("ret_rd_wen", rd_wen, exp_wen);
      check("ret_rd_addr", rd_addr, t.rd);
      if (exp_wen) check("ret_rd_wdata", rd_wdata, exp_data);
      tick();
      check("pulse_instr_ret", instr_ret, 0);
      check("pulse_rd_wen", rd_wen, 0);
    end
  endtask

  function automatic instr_t rand_instr();
    instr_t t;
    logic [6:0] sz;
    t = '0;
    t.rd = 5'($urandom_range(0, 31));
    t.wdata = {$urandom, $urandom};
    t.pc = {32'h0, $urandom} & ~64'd3;
    t.lat = 4'($urandom_range(0, 3));
    t.ack_dly = 4'($urandom_range(0, 3));
    t.rdata = {$urandom, $urandom};
    t.csr_rdata = {$urandom, $urandom};
    t.csr_addr = 12'($urandom);
    sz = 7'b0000100 << $urandom_range(0, 3);
    case ($urandom_range(0, 5))
      0: t.trap = 1'b1;
      1: begin t.wb_op = 2'd2; t.lsu_op = 7'b0000001 | sz | (7'($urandom_range(0, 1)) << 6); end
      2: begin t.wb_op = 2'($urandom_range(0, 1) * 2); t.lsu_op = 7'b0000010 | sz; end
      3: begin
        t.wb_op = 2'd3; t.csr_op = 4'($urandom_range(1, 15));
        t.csr_err = ($urandom_range(0, 3) == 0);
      end
      default: t.wb_op = 2'($urandom_range(0, 1));
    endcase
    if ((t.lsu_op[0] | t.lsu_op[1]) && t.lat != 4'd0) t.err = ($urandom_range(0, 4) == 0);
    return t;
  endfunction

  instr_t t;

  initial begin
    g_reset = 1'b1; s3_full = 1'b0; s3_pc = '0; s3_instr = '0; s3_wdata = '0; s3_rd = '0;
    s3_lsu_op = '0; s3_csr_op = '0; s3_csr_addr = '0; s3_wb_op = '0; s3_trap = 1'b0;
    dmem_rsp_valid = 1'b0; dmem_rsp_err = 1'b0; dmem_rsp_rdata = '0;
    csr_rdata = '0; csr_error = 1'b0; trap_ack = 1'b0;
    #12;
    check("rst_rd_wen", rd_wen, 0);
    check("rst_trap_valid", trap_valid, 0);
    check("rst_instr_ret", instr_ret, 0);
    check("rst_rd_wdata", rd_wdata, 0);
    tick();
    g_reset = 1'b0;
    #3;
    check("idle_ready", s3_ready, 1);
    tick();

    // ADD to x5
    t = '0; t.wb_op = 2'd1; t.rd = 5'd5; t.wdata = 64'h1234; t.pc = 64'h100;
    run(t);
    // LB sext at offset 3, response two cycles late
    t = '0; t.wb_op = 2'd2; t.rd = 5'd6; t.lsu_op = 7'b1000101; t.wdata = 64'h1003;
    t.lat = 4'd2; t.rdata = 64'h00000000_80000000; t.pc = 64'h104;
    run(t);
    // LHU at offset 6
    t = '0; t.wb_op = 2'd2; t.rd = 5'd7; t.lsu_op = 7'b0001001; t.wdata = 64'h2006;
    t.lat = 4'd1; t.rdata = 64'hBEEF0000_00000000; t.pc = 64'h108;
    run(t);
    // store with a faulting response
    t = '0; t.lsu_op = 7'b0010010; t.wdata = 64'h3000; t.lat = 4'd1; t.err = 1'b1;
    t.pc = 64'h10C; t.ack_dly = 4'd3;
    run(t);
    // CSRRW 0x300, then the same access faulting
    t = '0; t.wb_op = 2'd3; t.rd = 5'd8; t.csr_op = 4'b0011; t.csr_addr = 12'h300;
    t.csr_rdata = 64'hAA; t.wdata = 64'h55; t.pc = 64'h110;
    run(t);
    t.csr_err = 1'b1; t.pc = 64'h114; t.ack_dly = 4'd1;
    run(t);
    // ADD to x0 retires without writing
    t = '0; t.wb_op = 2'd1; t.rd = 5'd0; t.wdata = 64'h99; t.pc = 64'h118;
    run(t);
    // faulting load
    t = '0; t.wb_op = 2'd2; t.rd = 5'd9; t.lsu_op = 7'b0100001; t.lat = 4'd2; t.err = 1'b1;
    t.pc = 64'h11C;
    run(t);

    for (int i = 0; i < 80; i++) run(rand_instr());

    // leave nonzero trap state behind before the reset test
    t = '0; t.trap = 1'b1; t.pc = 64'h200;
    run(t);
    t = '0; t.wb_op = 2'd1; t.rd = 5'd3; t.wdata = 64'hCAFE; t.pc = 64'h204;
    run(t);

    // reset while waiting on memory; the late response must be ignored
    s3_full = 1'b1; s3_wb_op = 2'd2; s3_rd = 5'd4; s3_lsu_op = 7'b0100001; s3_csr_op = '0;
    s3_trap = 1'b0; s3_wdata = 64'h4000; s3_pc = 64'h208;
    tick();
    #2;
    g_reset = 1'b1;
    #1;
    check("mid_rst_rd_wen", rd_wen, 0);
    check("mid_rst_rd_addr", rd_addr, 0);
    check("mid_rst_rd_wdata", rd_wdata, 0);
    check("mid_rst_trap_cause", trap_cause, 0);
    check("mid_rst_trap_pc", trap_pc, 0);
    s3_full = 1'b0;
    tick();
    g_reset = 1'b0;
    dmem_rsp_valid = 1'b1; dmem_rsp_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    #3;
    check("late_rsp_ready", s3_ready, 1);
    tick();
    dmem_rsp_valid = 1'b0;
    check("late_rsp_rd_wen", rd_wen, 0);
    check("late_rsp_instr_ret", instr_ret, 0);
    check("late_rsp_rd_wdata", rd_wdata, 0);
    check("late_rsp_trap_valid", trap_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/core_pipe_wb.md
Name: core_pipe_wb

Overview:
Writeback stage (s3) of the core pipeline. It sits directly downstream of the execute stage and consumes the s3_* instruction registers that stage holds. It completes data-memory responses with load lane extraction and sign extension, and performs CSR accesses. It writes the register file, raises traps, and signals instruction retirement. Only this block makes architectural state changes visible.

Parameters:
XLEN, 64, datapath width; XL = XLEN-1.
TRAP_CAUSE_W, 7, trap cause width.

Ports:
g_clk  in  1  global clock
g_reset  in  1  asynchronous active-high reset
s3_full  in  1  execute stage holds a valid instruction for writeback
s3_ready  out  1  writeback consumes the s3 instruction this cycle
s3_pc  in  XLEN  instruction PC
s3_instr  in  32  instruction word
s3_wdata  in  XLEN  result data; for LSU ops, the effective address
s3_rd  in  5  destination register
s3_lsu_op  in  7  [0]load [1]store [2]byte [3]half [4]word [5]double [6]sext
s3_csr_op  in  4  [0]rd [1]wr [2]set [3]clr
s3_csr_addr  in  12  CSR address
s3_wb_op  in  2  0=none 1=WDATA 2=LSU 3=CSR
s3_trap  in  1  upstream trap request
dmem_rsp_valid  in  1  memory response valid
dmem_rsp_err  in  1  memory response error
dmem_rsp_rdata  in  XLEN  memory read data, aligned doubleword
csr_en  out  1  CSR access strobe
csr_wr  out  1  write
csr_set  out  1  set bits
csr_clr  out  1  clear bits
csr_addr  out  12  CSR address
csr_wdata  out  XLEN  CSR write operand (=s3_wdata)
csr_rdata  in  XLEN  CSR read data, same cycle
csr_error  in  1  illegal CSR access, same cycle
rd_wen  out  1  register file write enable (registered)
rd_addr  out  5  register file write address (registered)
rd_wdata  out  XLEN  register file write data (registered)
trap_valid  out  1  trap pending (registered)
trap_cause  out  TRAP_CAUSE_W  trap cause (registered)
trap_pc  out  XLEN  trapping PC (registered)
trap_ack  in  1  trap accepted by CSR/fetch
wb_flush  out  1  flush upstream stages (= trap_valid && trap_ack)
instr_ret  out  1  one-cycle retire pulse (registered)

Behaviour:
- Reset: the reset is asynchronous. On reset, the FSM goes to RUN, and rd_wen, trap_valid, instr_ret, rd_addr, rd_wdata, trap_cause and trap_pc all go to 0. A pending memory wait is abandoned and its response is ignored.
- FSM states are RUN, WAIT_MEM and TRAP.
- RUN with !s3_full: s3_ready=1 and there are no side effects.
- RUN with s3_full and s3_trap: go to TRAP and latch cause=2 and trap_pc=s3_pc. s3_ready=0.
- RUN with s3_full and an LSU op (load|store):
  - dmem_rsp_valid in the same cycle: complete now.
  - Otherwise: go to WAIT_MEM with s3_ready=0.
- WAIT_MEM: hold until dmem_rsp_valid.
  - Without error: complete (s3_ready=1) and return to RUN.
  - With dmem_rsp_err: go to TRAP with cause 5 (load) or 7 (store).
- RUN with s3_full and csr_op!=0:
  - csr_en=1 for exactly that cycle. csr_wr/set/clr mirror csr_op[1..3]; csr_addr=s3_csr_addr.
  - csr_error=1: go to TRAP with cause 2 and no rd write. Otherwise complete in the same cycle.
- Other ops complete in RUN in one cycle.
- TRAP: trap_valid=1 and s3_ready=0 until trap_ack. The trap_ack cycle sets s3_ready=1 (trapping instruction discarded), wb_flush=1, trap_valid<=0, state<=RUN. There is no rd write and no instr_ret for a trapping instruction.
- Completion cycle (s3_ready=1 with s3_full, no trap): on the next edge instr_ret<=1.
  - rd_wen<=1 only when s3_wb_op!=0 and s3_rd!=0.
  - rd_addr<=s3_rd.
  - Otherwise rd_wen and instr_ret go to 0 on the next edge (single-cycle pulses).
- rd_wdata selection:
  - WDATA: s3_wdata.
  - CSR: csr_rdata.
  - LSU: the extracted load.
- Load extraction: off=s3_wdata[2:0], shifted=dmem_rsp_rdata>>(8*off).
  - byte: shifted[7:0]. half: [15:0]. word: [31:0]. double: all bits.
  - Upper bits are replicated from the top loaded bit when sext=1, else zero.
- Stores: wait for the response but never write rd.
- dmem_rsp_valid in RUN with no LSU instruction present is ignored.
- csr_en is never asserted in WAIT_MEM or TRAP, or when s3_trap=1.

Test Plan:
- ADD, wb_op=1, rd=5, wdata=0x1234 -> s3_ready=1 same cycle; next cycle rd_wen=1, rd_addr=5, rd_wdata=0x1234, instr_ret=1 for 1 cycle.
- LB sext, addr ...03, rsp 2 cycles late with rdata=0x00000000_80000000 -> WAIT_MEM for 2 cycles, then rd_wdata=0xFFFFFFFFFFFFFF80. Repeat with LHU at addr ...06, rdata=0xBEEF000000000000 -> rd_wdata=0xBEEF.
- Store, rsp_err=1 -> trap_valid=1, cause=7, trap_pc=s3_pc, rd_wen=0. trap_ack after 3 cycles -> wb_flush=1 for 1 cycle, then RUN.
- CSRRW addr 0x300, csr_rdata=0xAA -> csr_en high exactly 1 cycle, csr_wr=1, rd_wdata=0xAA. Same access with csr_error=1 -> cause 2, no rd write, no instr_ret.
- rd=0 ADD -> instr_ret=1, rd_wen=0. Reset asserted mid-WAIT_MEM, late rsp arrives -> outputs 0, state RUN, rsp ignored.
